// File: rtl/hs32_mem_arb.sv
// Fetch/exec arbiter onto one valid/ready memory bus, one transaction at a time.
// Define HS32_ARB_RR_EN for round-robin on collisions (default: exec priority).
module hs32_mem_arb #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int TMO   = 0,
  parameter int TMO_W = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_rdy,
  output logic [DW-1:0] f_dtr,
  input  logic          e_req,
  input  logic          e_rw,
  input  logic [AW-1:0] e_addr,
  input  logic [DW-1:0] e_dtw,
  output logic          e_rdy,
  output logic [DW-1:0] e_dtr,
  output logic [AW-1:0] m_addr,
  output logic          m_rw,
  output logic [DW-1:0] m_dtw,
  output logic          m_valid,
  input  logic          m_ready,
  input  logic [DW-1:0] m_dtr,
  output logic          err,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_n;

  logic             gnt;
  logic             last;
  logic             win;
  logic             tmo_hit;
  logic             to;
  logic [TMO_W-1:0] cnt;
  logic [DW-1:0]    dtr;

  // win: 1 = exec, 0 = fetch
  always_comb begin
    win = e_req;
`ifdef HS32_ARB_RR_EN
    if (f_req && e_req) win = ~last;
`endif
  end

  assign tmo_hit = (TMO != 0) && (cnt == TMO_W'(TMO - 1));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (f_req || e_req) state_n = BUSY;
      BUSY: if (m_ready || tmo_hit) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      gnt    <= 1'b0;
      last   <= 1'b0;
      m_addr <= '0;
      m_rw   <= 1'b0;
      m_dtw  <= '0;
      cnt    <= '0;
      dtr    <= '0;
      to     <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (f_req || e_req) begin
            gnt    <= win;
            last   <= win;
            m_addr <= win ? e_addr : f_addr;
            m_rw   <= win & e_rw;
            m_dtw  <= win ? e_dtw : '0;
            cnt    <= '0;
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          // a response in the timeout cycle still counts as success
          if (m_ready) begin
            dtr <= m_rw ? '0 : m_dtr;
            to  <= 1'b0;
          end else if (tmo_hit) begin
            dtr <= '0;
            to  <= 1'b1;
          end
        end
        DONE: begin
          dtr <= '0;
          to  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign m_valid = (state == BUSY);
  assign busy    = (state != IDLE);
  assign f_rdy   = (state == DONE) && !gnt;
  assign e_rdy   = (state == DONE) && gnt;
  assign f_dtr   = f_rdy ? dtr : '0;
  assign e_dtr   = e_rdy ? dtr : '0;
  assign err     = (state == DONE) && to;

endmodule

// File: tb/tb_hs32_mem_arb.sv
// Directed bench for hs32_mem_arb built with TMO=4.
// Expectations follow HS32_ARB_RR_EN when defined.
module tb_hs32_mem_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_rdy;
  logic [31:0] f_dtr;
  logic        e_req;
  logic        e_rw;
  logic [31:0] e_addr;
  logic [31:0] e_dtw;
  logic        e_rdy;
  logic [31:0] e_dtr;
  logic [31:0] m_addr;
  logic        m_rw;
  logic [31:0] m_dtw;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_dtr;
  logic        err;
  logic        busy;

  int tests = 0;
  int fails = 0;

  hs32_mem_arb #(.AW(32), .DW(32), .TMO(4), .TMO_W(8)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_rdy(f_rdy), .f_dtr(f_dtr),
    .e_req(e_req), .e_rw(e_rw), .e_addr(e_addr), .e_dtw(e_dtw),
    .e_rdy(e_rdy), .e_dtr(e_dtr),
    .m_addr(m_addr), .m_rw(m_rw), .m_dtw(m_dtw), .m_valid(m_valid),
    .m_ready(m_ready), .m_dtr(m_dtr), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; f_req = 0; f_addr = 0; e_req = 0; e_rw = 0;
    e_addr = 0; e_dtw = 0; m_ready = 0; m_dtr = 0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_mvalid", m_valid, 0);
    chk("rst_frdy", f_rdy, 0);
    chk("rst_erdy", e_rdy, 0);
    chk("rst_err", err, 0);
    chk("rst_maddr", m_addr, 0);
    reset = 1'b0;
    step();
    chk("idle_busy", busy, 0);

    // 1: fetch read, m_ready two cycles after m_valid
    f_req = 1; f_addr = 32'h1000;
    step();
    chk("t1_mvalid", m_valid, 1);
    chk("t1_maddr", m_addr, 32'h1000);
    chk("t1_mrw", m_rw, 0);
    chk("t1_busy", busy, 1);
    step();
    chk("t1_mvalid2", m_valid, 1);
    step();
    m_ready = 1; m_dtr = 32'hCAFEBABE;
    step();
    chk("t1_frdy", f_rdy, 1);
    chk("t1_fdtr", f_dtr, 32'hCAFEBABE);
    chk("t1_erdy", e_rdy, 0);
    chk("t1_err", err, 0);
    chk("t1_mvalid_done", m_valid, 0);
    f_req = 0; m_ready = 0;
    step();
    chk("t1_frdy_off", f_rdy, 0);
    chk("t1_fdtr_off", f_dtr, 0);
    chk("t1_idle", busy, 0);

    // 2: collisions with both requests held
    f_req = 1; f_addr = 32'h2000;
    e_req = 1; e_rw = 1; e_addr = 32'h20; e_dtw = 32'hAAAA0000;
    m_ready = 1; m_dtr = 32'h11111111;
    step();
    chk("t2_maddr1", m_addr, 32'h20);
    chk("t2_mrw1", m_rw, 1);
    chk("t2_mdtw1", m_dtw, 32'hAAAA0000);
    step();
    chk("t2_erdy1", e_rdy, 1);
    chk("t2_edtr1", e_dtr, 0);
    chk("t2_frdy1", f_rdy, 0);
    step();
    step();
`ifdef HS32_ARB_RR_EN
    chk("t2_maddr2", m_addr, 32'h2000);
    chk("t2_mrw2", m_rw, 0);
    step();
    chk("t2_frdy2", f_rdy, 1);
    chk("t2_fdtr2", f_dtr, 32'h11111111);
    chk("t2_erdy2", e_rdy, 0);
`else
    chk("t2_maddr2", m_addr, 32'h20);
    chk("t2_mrw2", m_rw, 1);
    step();
    chk("t2_erdy2", e_rdy, 1);
    chk("t2_frdy2", f_rdy, 0);
    chk("t2_fdtr2", f_dtr, 0);
`endif
    f_req = 0; e_req = 0; e_rw = 0;
    step();

    // 3: exec read held continuously, m_ready tied high
    e_req = 1; e_addr = 32'h40; m_ready = 1; m_dtr = 32'h12345678;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("t3_mvalid_%0d", i), m_valid, (i % 3 == 0) ? 1 : 0);
      chk($sformatf("t3_erdy_%0d", i), e_rdy, (i % 3 == 1) ? 1 : 0);
      chk($sformatf("t3_edtr_%0d", i), e_dtr,
          (i % 3 == 1) ? 32'h12345678 : 32'h0);
    end
    e_req = 0; m_ready = 0;
    step();

    // 4: timeout after 4 BUSY cycles, then a clean transaction
    e_req = 1; e_addr = 32'h80; m_dtr = 32'hDEADDEAD;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t4_mvalid_%0d", i), m_valid, 1);
      chk($sformatf("t4_err_%0d", i), err, 0);
    end
    step();
    chk("t4_erdy", e_rdy, 1);
    chk("t4_err", err, 1);
    chk("t4_edtr", e_dtr, 0);
    chk("t4_mvalid_done", m_valid, 0);
    m_ready = 1; m_dtr = 32'h00000055;
    step();
    chk("t4_err_idle", err, 0);
    step();
    step();
    chk("t4b_erdy", e_rdy, 1);
    chk("t4b_err", err, 0);
    chk("t4b_edtr", e_dtr, 32'h55);
    e_req = 0; m_ready = 0;
    step();

    // 5: reset while BUSY
    f_req = 1; f_addr = 32'h300;
    step();
    chk("t5_busy", busy, 1);
    reset = 1;
    step();
    chk("t5_mvalid", m_valid, 0);
    chk("t5_busy_rst", busy, 0);
    reset = 0; f_req = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t5_frdy_%0d", i), f_rdy, 0);
      chk($sformatf("t5_erdy_%0d", i), e_rdy, 0);
      chk($sformatf("t5_busy_%0d", i), busy, 0);
    end

    // 6: m_ready in the 4th BUSY cycle beats the timeout
    e_req = 1; e_rw = 0; e_addr = 32'h90;
    step();
    step();
    step();
    step();
    chk("t6_mvalid4", m_valid, 1);
    m_ready = 1; m_dtr = 32'hBBBBBBBB;
    step();
    chk("t6_erdy", e_rdy, 1);
    chk("t6_err", err, 0);
    chk("t6_edtr", e_dtr, 32'hBBBBBBBB);
    e_req = 0; m_ready = 0;
    step();
    chk("t6_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
